// File: rtl/mmio_test_pkg.sv
// rtl/mmio_test_pkg.sv - shared register map and constants for the mmio test device
package mmio_test_pkg;

    typedef enum logic [1:0] {
        REG_TOHOST    = 2'd0,
        REG_CONSOLE   = 2'd1,
        REG_MCYCLE_LO = 2'd2,
        REG_MCYCLE_HI = 2'd3
    } reg_idx_e;

    localparam logic [31:0] DEFAULT_PASS_CODE = 32'h0000_0777;

    localparam int SEL_BIT_HI = 31;
    localparam int SEL_BIT_LO = 18;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with wrap-bit pointers and last-value hold when empty
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] last_q;
    logic             do_push;
    logic             do_pop;

    assign count   = wptr - rptr;
    assign empty   = (wptr == rptr);
    assign full    = (count == DEPTH[AW:0]);
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign do_push = push & (~full | do_pop);

    assign head_data = empty ? last_q : mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr   <= '0;
            rptr   <= '0;
            last_q <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr   <= rptr + 1'b1;
                last_q <= mem[rptr[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/mmio_test_dev.sv
// rtl/mmio_test_dev.sv - simulation-control responder: TOHOST latch, console FIFO, mcycle counter
module mmio_test_dev
    import mmio_test_pkg::*;
#(
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] PASS_CODE  = DEFAULT_PASS_CODE
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dbus_addr_i,
    input  logic        dbus_wvalid_i,
    input  logic [31:0] dbus_wdata_i,
    input  logic        dbus_rreq_i,
    output logic        dbus_rvalid_o,
    output logic [31:0] dbus_rdata_o,
    output logic        console_valid_o,
    output logic [7:0]  console_data_o,
    input  logic        console_ready_i,
    output logic        done_o,
    output logic        pass_o,
    output logic [31:0] fail_code_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          sel;
    reg_idx_e      idx;
    logic          wr;
    logic          rd;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [4:0]    count_field;
    logic          ovf;
    logic [63:0]   mcycle;
    logic [31:0]   hi_snap;
    logic [31:0]   rd_mux;
    logic          unused_addr_bits;

    assign sel = dbus_addr_i[SEL_BIT_HI] & dbus_addr_i[SEL_BIT_LO];
    assign idx = reg_idx_e'(dbus_addr_i[3:2]);
    assign wr  = dbus_wvalid_i & sel;
    assign rd  = dbus_rreq_i & sel;

    assign unused_addr_bits = ^{dbus_addr_i[30:19], dbus_addr_i[17:4], dbus_addr_i[1:0]};

    assign fifo_push       = wr & (idx == REG_CONSOLE);
    assign fifo_pop        = console_valid_o & console_ready_i;
    assign console_valid_o = ~fifo_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_console_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .push      (fifo_push),
        .push_data (dbus_wdata_i[7:0]),
        .pop       (fifo_pop),
        .head_data (console_data_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Deep FIFOs report a pegged count rather than a wrapped one.
    assign count_field = (int'(fifo_count) > 31) ? 5'd31 : 5'(fifo_count);

    always_comb begin
        rd_mux = '0;
        case (idx)
            REG_TOHOST:    rd_mux = fail_code_o;
            REG_CONSOLE:   rd_mux = {ovf, 26'b0, count_field};
            REG_MCYCLE_LO: rd_mux = mcycle[31:0];
            REG_MCYCLE_HI: rd_mux = hi_snap;
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_o        <= 1'b0;
            pass_o        <= 1'b0;
            fail_code_o   <= '0;
            ovf           <= 1'b0;
            mcycle        <= '0;
            hi_snap       <= '0;
            dbus_rvalid_o <= 1'b0;
            dbus_rdata_o  <= '0;
        end else begin
            if (!done_o) begin
                mcycle <= mcycle + 64'd1;
            end

            if (wr && idx == REG_TOHOST && dbus_wdata_i != 32'd0 && !done_o) begin
                fail_code_o <= dbus_wdata_i;
                done_o      <= 1'b1;
                pass_o      <= (dbus_wdata_i == PASS_CODE);
            end

            if (fifo_push && fifo_full && !fifo_pop) begin
                ovf <= 1'b1;
            end else if (wr && idx == REG_MCYCLE_HI) begin
                ovf <= 1'b0;
            end

            // LO read latches the upper half so a LO-then-HI pair is coherent.
            if (rd && idx == REG_MCYCLE_LO) begin
                hi_snap <= mcycle[63:32];
            end

            dbus_rvalid_o <= rd;
            dbus_rdata_o  <= rd ? rd_mux : 32'd0;
        end
    end

endmodule
